// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce, ghost rejection and hex entry register
//
// Drives one keypad row low at a time and samples the synchronized columns
// once per row. After each complete 4-row scan, the scan result goes to a
// debounce FSM. The FSM accepts a single key only after DEBOUNCE_SCANS
// consecutive identical scans. It then pulses key_valid and shifts the digit
// into entry.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   row[3:0]   row drive, active-low, exactly one bit low
//   col[3:0]   column sense, active-low, asynchronous to clk
//   entry_clr  synchronous clear of entry (wins over a same-cycle accept)
//   key_valid  one-cycle pulse per accepted key press
//   key_code   hex code of the last accepted key
//   key_down   high while the accepted key is considered held
//   entry      digit shift register, newest digit in [3:0]
module keypad_scanner #(
   parameter int SCAN_DIV       = 500,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [3:0]  row,
   input  logic [3:0]  col,
   input  logic        entry_clr,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_down,
   output logic [15:0] entry
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int NW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

   state_t        state, state_next;
   logic [DW-1:0] dwell;
   logic [1:0]    idx;
   logic [3:0]    col_meta, col_sync;
   logic [1:0]    acc_hits;
   logic [3:0]    acc_pos;
   logic [NW-1:0] n, n_next;
   logic [3:0]    cand, cand_next;
   logic          sample, scan_done, accept;
   logic [2:0]    col_hits;
   logic [1:0]    col_idx;
   logic [2:0]    total_hits;
   logic [3:0]    hit_code;
   logic          res_none, res_single;

   function automatic logic [3:0] key_map(input logic [3:0] pos);
      case (pos)
         4'd0:    return 4'h1;
         4'd1:    return 4'h2;
         4'd2:    return 4'h3;
         4'd3:    return 4'hA;
         4'd4:    return 4'h4;
         4'd5:    return 4'h5;
         4'd6:    return 4'h6;
         4'd7:    return 4'hB;
         4'd8:    return 4'h7;
         4'd9:    return 4'h8;
         4'd10:   return 4'h9;
         4'd11:   return 4'hC;
         4'd12:   return 4'hE;
         4'd13:   return 4'h0;
         4'd14:   return 4'hF;
         default: return 4'hD;
      endcase
   endfunction

   assign sample    = (dwell == DW'(SCAN_DIV - 1));
   assign scan_done = sample && (idx == 2'd3);

   // Count low columns in the current sample. col_idx keeps the lowest low
   // bit, and it is only used when that bit is the sole hit.
   always_comb begin
      col_hits = '0;
      col_idx  = '0;
      for (int i = 3; i >= 0; i--) begin
         if (!col_sync[i]) begin
            col_hits = col_hits + 3'd1;
            col_idx  = 2'(i);
         end
      end
   end

   // The result includes the sample being taken this cycle, so scan_done sees
   // all four rows without waiting for the accumulator to update.
   assign total_hits = {1'b0, acc_hits} + col_hits;
   assign res_none   = (total_hits == 3'd0);
   assign res_single = (total_hits == 3'd1);
   assign hit_code   = key_map((col_hits != 3'd0) ? {idx, col_idx} : acc_pos);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_meta <= 4'b1111;
         col_sync <= 4'b1111;
         dwell    <= '0;
         idx      <= 2'd0;
         row      <= 4'b1110;
         acc_hits <= 2'd0;
         acc_pos  <= 4'd0;
      end else begin
         col_meta <= col;
         col_sync <= col_meta;
         if (sample) begin
            dwell <= '0;
            idx   <= idx + 2'd1;
            row   <= {row[2:0], row[3]};
            if (idx == 2'd3) begin
               acc_hits <= 2'd0;
               acc_pos  <= 4'd0;
            end else begin
               // Saturate at 2; anything above one hit is treated as MULTI.
               acc_hits <= (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
               if (col_hits != 3'd0) acc_pos <= {idx, col_idx};
            end
         end else begin
            dwell <= dwell + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      n_next     = n;
      cand_next  = cand;
      accept     = 1'b0;
      if (scan_done) begin
         case (state)
            IDLE: begin
               if (res_single) begin
                  cand_next = hit_code;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_next = HELD;
                     accept     = 1'b1;
                  end else begin
                     state_next = PRESS_CHK;
                     n_next     = NW'(1);
                  end
               end
            end
            PRESS_CHK: begin
               if (res_single && (hit_code == cand)) begin
                  if (int'(n) + 1 >= DEBOUNCE_SCANS) begin
                     state_next = HELD;
                     accept     = 1'b1;
                  end else begin
                     n_next = n + 1'b1;
                  end
               end else if (res_single) begin
                  cand_next = hit_code;
                  n_next    = NW'(1);
               end else begin
                  state_next = IDLE;
               end
            end
            HELD: begin
               // MULTI counts as still held, so a second key adds no event.
               if (res_none) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_next = IDLE;
                  end else begin
                     state_next = RELEASE_CHK;
                     n_next     = NW'(1);
                  end
               end
            end
            default: begin
               if (res_none) begin
                  if (int'(n) + 1 >= DEBOUNCE_SCANS) state_next = IDLE;
                  else                               n_next     = n + 1'b1;
               end else begin
                  state_next = HELD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         n         <= '0;
         cand      <= 4'd0;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         key_down  <= 1'b0;
         entry     <= 16'h0000;
      end else begin
         state     <= state_next;
         n         <= n_next;
         cand      <= cand_next;
         key_valid <= accept;
         key_down  <= (state_next == HELD) || (state_next == RELEASE_CHK);
         if (accept) key_code <= cand_next;
         if (entry_clr)   entry <= 16'h0000;
         else if (accept) entry <= {entry[11:0], cand_next};
      end
   end

endmodule
